mem_req_ctrl: RTL and testbench

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

---
 rtl/mem_pkg.sv | 47 ++++
 rtl/mem_req_ctrl_if.sv | 43 ++++
 rtl/mem_req_ctrl_rsp_fifo.sv | 70 +++++++
 rtl/mem_req_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_req_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory request controller: access sizes,
// memory read latency, pipeline entry layout and decode helpers.
package mem_pkg;

    // Cycles from raddr presentation to rdata being valid.
    localparam int MEM_RD_LATENCY = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    // One in-flight request travelling alongside the memory read.
    // The tag rides in a parallel register because its width is a
    // module parameter and a package type cannot depend on it.
    typedef struct packed {
        logic       valid;
        logic       we;
        logic       err;
        size_e      size;
        logic       sgn;
        logic [1:0] lane;
    } pipe_entry_t;

    // Illegal size or an address not aligned to the access size.
    function automatic logic size_err(input size_e size, input logic [1:0] lane);
        case (size)
            SZ_HALF: return lane[0];
            SZ_WORD: return (lane != 2'b00);
            SZ_ILL:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Byte enables for a store of the given size at the given byte lane.
    function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return 4'b0011 << lane;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Core request/response and memory-side signals of the controller.
interface mem_req_ctrl_if
    import mem_pkg::*;
#(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_signed;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    logic [31:0]      raddr;
    logic [31:0]      rdata;
    logic [3:0]       wen;
    logic [31:0]      waddr;
    logic [31:0]      wdata;

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_tag,
        input  rsp_ready, rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err, rsp_tag,
        output raddr, wen, waddr, wdata
    );

    // Core plus memory side.
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_tag,
        output rsp_ready, rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_tag,
        input  raddr, wen, waddr, wdata
    );
endinterface

// File: rtl/mem_req_ctrl_rsp_fifo.sv
// Response FIFO: valid/ready on both sides, pointers wrap modulo DEPTH
// so non power-of-two depths work. Output data reads as zero when empty.
module rsp_fifo
    import mem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A full FIFO can still accept when the head leaves in the same cycle.
    assign out_valid_o = (count_q != '0);
    assign in_ready_o  = (count_q != CNT_W'(DEPTH)) || out_ready_i;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;

    // Next-state for pointers and fill count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since count gates the output.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end
endmodule

// File: rtl/mem_req_ctrl.sv
// Load/store request controller: decodes core requests into memory
// reads/writes, tracks each request through the read latency and returns
// in-order responses through a credit-limited response FIFO.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_req_ctrl_if.slave    bus
);
    localparam int OCC_W = $clog2(RSP_DEPTH + 1);
    localparam int RSP_W = 32 + 1 + TAG_W;

    size_e            req_size_e;
    logic [1:0]       req_lane;
    logic             req_err;
    logic             accept;
    logic             pop;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [31:0]      wdata_lanes;
    pipe_entry_t      entry_in;
    pipe_entry_t      pipe_q [MEM_RD_LATENCY];
    logic [TAG_W-1:0] tag_q  [MEM_RD_LATENCY];
    pipe_entry_t      tail;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      rsp_data_in;
    logic             fifo_in_ready;
    logic             rsp_valid_w;
    logic [RSP_W-1:0] fifo_out;

    assign req_size_e = size_e'(bus.req_size);
    assign req_lane   = bus.req_addr[1:0];
    assign req_err    = size_err(req_size_e, req_lane);

    // Credits cover requests still in the pipeline as well as those
    // waiting in the FIFO, so a slot is always free when one exits.
    assign bus.req_ready = (occ_q < OCC_W'(RSP_DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;
    assign pop           = rsp_valid_w && bus.rsp_ready;

    // Occupancy next-state: accept and pop in one cycle cancel out.
    always_comb begin
        occ_d = occ_q;
        case ({accept, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ_q <= '0;
        else        occ_q <= occ_d;
    end

    // Memory side: the read address follows req_addr every cycle; writes
    // go out combinationally in the accept cycle.
    assign bus.raddr = {bus.req_addr[31:2], 2'b00};
    assign bus.waddr = {bus.req_addr[31:2], 2'b00};
    assign bus.wen   = (accept && bus.req_we && !req_err) ? byte_en(req_size_e, req_lane) : 4'b0000;
    assign bus.wdata = wdata_lanes;

    // Replicate store data so every enabled lane sees the right bytes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
        assign wdata_lanes[8*gi +: 8] =
            (req_size_e == SZ_BYTE) ? bus.req_wdata[7:0] :
            (req_size_e == SZ_HALF) ? bus.req_wdata[8*(gi % 2) +: 8] :
                                      bus.req_wdata[8*gi +: 8];
    end

    always_comb begin
        entry_in       = '0;
        entry_in.valid = accept;
        entry_in.we    = bus.req_we;
        entry_in.err   = req_err;
        entry_in.size  = req_size_e;
        entry_in.sgn   = bus.req_signed;
        entry_in.lane  = req_lane;
    end

    // Shift pipeline matching the memory read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_RD_LATENCY; i++) begin
                pipe_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            pipe_q[0] <= entry_in;
            tag_q[0]  <= bus.req_tag;
            for (int i = 1; i < MEM_RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    assign tail     = pipe_q[MEM_RD_LATENCY-1];
    assign byte_sel = bus.rdata[{tail.lane, 3'b000} +: 8];
    assign half_sel = tail.lane[1] ? bus.rdata[31:16] : bus.rdata[15:0];

    // Load lane extraction and extension; stores and errors return zero.
    always_comb begin
        rsp_data_in = '0;
        if (!tail.we && !tail.err) begin
            case (tail.size)
                SZ_BYTE: rsp_data_in = {{24{tail.sgn & byte_sel[7]}}, byte_sel};
                SZ_HALF: rsp_data_in = {{16{tail.sgn & half_sel[15]}}, half_sel};
                SZ_WORD: rsp_data_in = bus.rdata;
                default: rsp_data_in = '0;
            endcase
        end
    end

    // fifo_in_ready is always high when an entry exits thanks to the credits.
    rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (tail.valid && fifo_in_ready),
        .in_ready_o  (fifo_in_ready),
        .in_data_i   ({rsp_data_in, tail.err, tag_q[MEM_RD_LATENCY-1]}),
        .out_valid_o (rsp_valid_w),
        .out_ready_i (bus.rsp_ready),
        .out_data_o  (fifo_out)
    );

    assign bus.rsp_valid = rsp_valid_w;
    assign bus.rsp_data  = fifo_out[RSP_W-1 -: 32];
    assign bus.rsp_err   = fifo_out[TAG_W];
    assign bus.rsp_tag   = fifo_out[TAG_W-1:0];
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a 2-cycle-latency memory model.
module tb_mem_req_ctrl;
    import mem_pkg::*;

    localparam int TAG_W = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_req_ctrl_if #(.TAG_W(TAG_W)) bus();

    mem_req_ctrl #(.RSP_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Memory model: byte-enabled writes, two-register read path.
    logic [31:0] mem_model [256];
    logic [31:0] rd_stage;
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bus.wen[b]) mem_model[bus.waddr[9:2]][8*b +: 8] <= bus.wdata[8*b +: 8];
        rd_stage  <= mem_model[bus.raddr[9:2]];
        bus.rdata <= rd_stage;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic idle;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_tag    = '0;
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [TAG_W-1:0] tag);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_tag    = tag;
    endtask

    task automatic test_reset;
        idle();
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.wen !== 4'b0000) begin errors++; $display("FAIL reset_wen: got %b expected 0000", bus.wen); end
        checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 00000000", bus.rsp_data); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err); end
        checks++; if (bus.rsp_tag !== 4'd0) begin errors++; $display("FAIL reset_rsp_tag: got %0d expected 0", bus.rsp_tag); end
        rst_n = 1'b1;
        $display("reset released");
    endtask

    // First request right after reset release: also proves immediate accept.
    task automatic test_store_byte;
        drive(1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00AB, 4'd1);
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL sb_ready: got %b expected 1", bus.req_ready); end
        checks++; if (bus.wen !== 4'b1000) begin errors++; $display("FAIL sb_wen: got %b expected 1000", bus.wen); end
        checks++; if (bus.waddr !== 32'h100) begin errors++; $display("FAIL sb_waddr: got %h expected 00000100", bus.waddr); end
        checks++; if (bus.wdata !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata: got %h expected abababab", bus.wdata); end
        tick();
        idle();
        #1;
        checks++; if (bus.wen !== 4'b0000) begin errors++; $display("FAIL sb_wen_idle: got %b expected 0000", bus.wen); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL sb_early_rsp: got %b expected 0", bus.rsp_valid); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL sb_rsp_valid: got %b expected 1", bus.rsp_valid); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL sb_rsp_err: got %b expected 0", bus.rsp_err); end
        checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL sb_rsp_data: got %h expected 00000000", bus.rsp_data); end
        checks++; if (bus.rsp_tag !== 4'd1) begin errors++; $display("FAIL sb_rsp_tag: got %0d expected 1", bus.rsp_tag); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL sb_rsp_drain: got %b expected 0", bus.rsp_valid); end
        $display("store byte 0x103 tag 1 done");
    endtask

    task automatic test_loads;
        logic        we_v  [5];
        logic [1:0]  sz_v  [5];
        logic        sg_v  [5];
        logic [31:0] ad_v  [5];
        logic [3:0]  wen_v [5];
        logic [31:0] dat_v [5];
        we_v  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        sz_v  = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1};
        sg_v  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        ad_v  = '{32'h100, 32'h103, 32'h101, 32'h102, 32'h100};
        wen_v = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        dat_v = '{32'h0, 32'hFFFFFF80, 32'h0000007F, 32'h000080FF, 32'h00007F01};
        for (int c = 0; c < 8; c++) begin
            if (c < 5) drive(we_v[c], sz_v[c], sg_v[c], ad_v[c], 32'h80FF7F01, 4'(c + 2));
            else       idle();
            #1;
            if (c < 5) begin
                checks++; if (bus.wen !== wen_v[c]) begin errors++; $display("FAIL ld_wen[%0d]: got %b expected %b", c, bus.wen, wen_v[c]); end
            end
            tick();
            if (c >= 2 && c - 2 < 5) begin
                checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'(c) || bus.rsp_data !== dat_v[c-2] || bus.rsp_err !== 1'b0) begin
                    errors++; $display("FAIL ld_rsp[%0d]: got v=%b tag=%0d data=%h err=%b expected v=1 tag=%0d data=%h err=0",
                                       c - 2, bus.rsp_valid, bus.rsp_tag, bus.rsp_data, bus.rsp_err, c, dat_v[c-2]);
                end
                $display("rsp tag %0d data %h", bus.rsp_tag, bus.rsp_data);
            end else begin
                checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL ld_idle_rsp[%0d]: got %b expected 0", c, bus.rsp_valid); end
            end
        end
    endtask

    task automatic test_errors;
        logic        we_v  [5];
        logic [1:0]  sz_v  [5];
        logic [31:0] ad_v  [5];
        logic [31:0] wd_v  [5];
        logic [3:0]  wen_v [5];
        logic        err_v [5];
        logic [31:0] dat_v [5];
        we_v  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        sz_v  = '{2'd2, 2'd1, 2'd3, 2'd1, 2'd1};
        ad_v  = '{32'h102, 32'h101, 32'h100, 32'h202, 32'h202};
        wd_v  = '{32'h0, 32'h1234, 32'h0, 32'hBEEF, 32'h0};
        wen_v = '{4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b0000};
        err_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        dat_v = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0000BEEF};
        for (int c = 0; c < 8; c++) begin
            if (c < 5) drive(we_v[c], sz_v[c], 1'b0, ad_v[c], wd_v[c], 4'(c + 5));
            else       idle();
            #1;
            if (c < 5) begin
                checks++; if (bus.wen !== wen_v[c]) begin errors++; $display("FAIL err_wen[%0d]: got %b expected %b", c, bus.wen, wen_v[c]); end
            end
            if (c == 3) begin
                checks++; if (bus.wdata !== 32'hBEEFBEEF || bus.waddr !== 32'h200) begin
                    errors++; $display("FAIL half_store_bus: got wdata=%h waddr=%h expected beefbeef 00000200", bus.wdata, bus.waddr);
                end
            end
            tick();
            if (c >= 2 && c - 2 < 5) begin
                checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'(c + 3) || bus.rsp_data !== dat_v[c-2] || bus.rsp_err !== err_v[c-2]) begin
                    errors++; $display("FAIL err_rsp[%0d]: got v=%b tag=%0d data=%h err=%b expected v=1 tag=%0d data=%h err=%b",
                                       c - 2, bus.rsp_valid, bus.rsp_tag, bus.rsp_data, bus.rsp_err, c + 3, dat_v[c-2], err_v[c-2]);
                end
                $display("rsp tag %0d err %b data %h", bus.rsp_tag, bus.rsp_err, bus.rsp_data);
            end else begin
                checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL err_idle_rsp[%0d]: got %b expected 0", c, bus.rsp_valid); end
            end
        end
    endtask

    task automatic test_backpressure;
        int  acc = 0;
        int  got = 0;
        logic hs;
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (acc < 6) drive(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 4'(acc));
            else         idle();
            #1;
            hs = bus.req_valid && bus.req_ready;
            tick();
            if (hs) acc++;
            if (c >= 2) begin
                checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'd0 || bus.rsp_data !== 32'h80FF7F01) begin
                    errors++; $display("FAIL bp_hold[%0d]: got v=%b tag=%0d data=%h expected v=1 tag=0 data=80ff7f01",
                                       c, bus.rsp_valid, bus.rsp_tag, bus.rsp_data);
                end
            end
        end
        checks++; if (acc !== 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", acc); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", bus.req_ready); end
        $display("backpressure: %0d accepted while stalled", acc);
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 30 && got < 6; c++) begin
            if (acc < 6) drive(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 4'(acc));
            else         idle();
            #1;
            hs = bus.req_valid && bus.req_ready;
            if (bus.rsp_valid === 1'b1) begin
                checks++; if (bus.rsp_tag !== 4'(got) || bus.rsp_data !== 32'h80FF7F01) begin
                    errors++; $display("FAIL bp_order[%0d]: got tag=%0d data=%h expected tag=%0d data=80ff7f01",
                                       got, bus.rsp_tag, bus.rsp_data, got);
                end
                $display("drain rsp tag %0d", bus.rsp_tag);
                got++;
            end
            tick();
            if (hs) acc++;
        end
        idle();
        checks++; if (got !== 6 || acc !== 6) begin errors++; $display("FAIL bp_drain: got rsps=%0d accepted=%0d expected 6 6", got, acc); end
        tick();
    endtask

    task automatic test_store_load;
        for (int c = 0; c < 6; c++) begin
            if (c == 0)      drive(1'b1, 2'd2, 1'b0, 32'h200, 32'h11223344, 4'd1);
            else if (c == 1) drive(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 4'd2);
            else             idle();
            tick();
            if (c == 2 || c == 3) begin
                checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'(c - 1) ||
                              bus.rsp_data !== ((c == 2) ? 32'h0 : 32'h11223344)) begin
                    errors++; $display("FAIL st_ld_rsp[%0d]: got v=%b tag=%0d data=%h expected tag=%0d data=%h", c - 2,
                                       bus.rsp_valid, bus.rsp_tag, bus.rsp_data, c - 1, (c == 2) ? 32'h0 : 32'h11223344);
                end
                $display("rsp tag %0d data %h", bus.rsp_tag, bus.rsp_data);
            end else begin
                checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL st_ld_idle[%0d]: got %b expected 0", c, bus.rsp_valid); end
            end
        end
    endtask

    task automatic test_reset_midflight;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 4'(c + 9));
            tick();
        end
        idle();
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rm_inflight: got %b expected 1", bus.rsp_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL rm_async: got rsp_valid=%b req_ready=%b expected 0 1", bus.rsp_valid, bus.req_ready);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
                errors++; $display("FAIL rm_after[%0d]: got rsp_valid=%b req_ready=%b expected 0 1", c, bus.rsp_valid, bus.req_ready);
            end
        end
        $display("reset mid-flight: no stale responses");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_byte();
        test_loads();
        test_errors();
        test_backpressure();
        test_store_load();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
